// File: rtl/stream_fifo_vc_pkg.sv
// Shared types and round-robin helpers for the multi-VC stream FIFO.
package stream_fifo_vc_pkg;

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} arb_state_e;

  // Upper bound on NumVc; helpers work on a mask zero-extended to this width.
  localparam int MaxVc  = 32;
  localparam int MaxVcW = $clog2(MaxVc);

  function automatic int rr_next(int idx, int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // Unused upper mask bits are zero, so a wrap mod MaxVc visits VCs in the
  // same order as a wrap mod NumVc would.
  function automatic int rr_pick(logic [MaxVc-1:0] mask, int start);
    int              pick;
    logic [MaxVcW-1:0] idx;
    pick = start;
    for (int i = MaxVc - 1; i >= 0; i--) begin
      idx = MaxVcW'((start + i) % MaxVc);
      if (mask[idx]) pick = int'(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/stream_fifo_vc_if.sv
// Enqueue/dequeue stream bundle for stream_fifo_vc; slave = FIFO side.
interface stream_fifo_vc_if #(
  parameter int NumVc     = 4,
  parameter int WordWidth = 64
);
  localparam int VcW = $clog2(NumVc);

  logic                 enq_vld_i;
  logic [VcW-1:0]       enq_vc_i;
  logic [WordWidth-1:0] enq_payload_i;
  logic [NumVc-1:0]     enq_rdy_o;
  logic                 deq_vld_o;
  logic [VcW-1:0]       deq_vc_o;
  logic [WordWidth-1:0] deq_payload_o;
  logic                 deq_rdy_i;
  logic                 flush_i;

  modport slave (
    input  enq_vld_i, enq_vc_i, enq_payload_i, deq_rdy_i, flush_i,
    output enq_rdy_o, deq_vld_o, deq_vc_o, deq_payload_o
  );

  modport master (
    output enq_vld_i, enq_vc_i, enq_payload_i, deq_rdy_i, flush_i,
    input  enq_rdy_o, deq_vld_o, deq_vc_o, deq_payload_o
  );
endinterface

// File: rtl/stream_fifo_vc_arb.sv
// Round-robin dequeue arbiter; LOCK holds the presented VC until it fires.
module stream_fifo_vc_arb
  import stream_fifo_vc_pkg::*;
#(
  parameter  int NumVc = 4,
  localparam int VcW   = $clog2(NumVc)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NumVc-1:0] nonempty_i,
  input  logic             deq_rdy_i,
  input  logic             flush_i,
  output logic [VcW-1:0]   grant_o,
  output logic             grant_vld_o
);

  arb_state_e     state_q, state_d;
  logic [VcW-1:0] rr_q, rr_d, lock_vc_q, lock_vc_d, pick;

  assign pick        = VcW'(rr_pick(MaxVc'(nonempty_i), int'(rr_q)));
  assign grant_o     = (state_q == LOCK) ? lock_vc_q : pick;
  assign grant_vld_o = (state_q == LOCK) | (|nonempty_i);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ARB;
      rr_q      <= '0;
      lock_vc_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      lock_vc_q <= lock_vc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    lock_vc_d = lock_vc_q;
    if (flush_i) begin
      state_d = ARB;
      rr_d    = '0;
    end else begin
      case (state_q)
        ARB: begin
          if (grant_vld_o && !deq_rdy_i) begin
            lock_vc_d = grant_o;
            state_d   = LOCK;
          end else if (grant_vld_o) begin
            rr_d = VcW'(rr_next(int'(grant_o), NumVc));
          end
        end
        LOCK: begin
          if (deq_rdy_i) begin
            rr_d    = VcW'(rr_next(int'(lock_vc_q), NumVc));
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

endmodule

// File: rtl/stream_fifo_vc.sv
// Multi-VC stream FIFO: per-VC circular queues, one VC-tagged enqueue port,
// one round-robin dequeue stream. Define STREAM_FIFO_VC_OCC_EN for occ_o.
module stream_fifo_vc
  import stream_fifo_vc_pkg::*;
#(
  parameter  int NumVc     = 4,
  parameter  int Depth     = 4,
  parameter  int WordWidth = 64,
  localparam int VcW       = $clog2(NumVc),
  localparam int CntW      = $clog2(Depth + 1),
  localparam int PtrW      = $clog2(Depth)
) (
  input  logic                  clk,
  input  logic                  rstn,
  stream_fifo_vc_if.slave       s
`ifdef STREAM_FIFO_VC_OCC_EN
  ,
  output logic [NumVc*CntW-1:0] occ_o
`endif
);

  logic [WordWidth-1:0]           mem_q [NumVc][Depth];
  logic [NumVc-1:0][PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [NumVc-1:0][CntW-1:0]     cnt_q;
  logic [NumVc-1:0]               full, nonempty, enq_sel, deq_sel;
  logic                           vc_ok, enq_fire, deq_fire, grant_vld;
  logic [VcW-1:0]                 grant;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign vc_ok    = int'(s.enq_vc_i) < NumVc;
  assign enq_fire = s.enq_vld_i & vc_ok & ~full[s.enq_vc_i];
  assign deq_fire = grant_vld & s.deq_rdy_i;

  for (genvar v = 0; v < NumVc; v++) begin : g_vc
    assign full[v]     = cnt_q[v] == CntW'(Depth);
    assign nonempty[v] = cnt_q[v] != '0;
    assign enq_sel[v]  = enq_fire & (s.enq_vc_i == VcW'(v)) & ~s.flush_i;
    assign deq_sel[v]  = deq_fire & (grant == VcW'(v)) & ~s.flush_i;
  end

  stream_fifo_vc_arb #(.NumVc(NumVc)) u_arb (
    .clk         (clk),
    .rstn        (rstn),
    .nonempty_i  (nonempty),
    .deq_rdy_i   (s.deq_rdy_i),
    .flush_i     (s.flush_i),
    .grant_o     (grant),
    .grant_vld_o (grant_vld)
  );

  // Full/empty come from the count, so pointers never need an extra wrap bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (s.flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int v = 0; v < NumVc; v++) begin
        if (enq_sel[v]) wr_ptr_q[v] <= ptr_inc(wr_ptr_q[v]);
        if (deq_sel[v]) rd_ptr_q[v] <= ptr_inc(rd_ptr_q[v]);
        cnt_q[v] <= cnt_q[v] + CntW'(enq_sel[v]) - CntW'(deq_sel[v]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NumVc; v++)
      if (enq_sel[v]) mem_q[v][wr_ptr_q[v]] <= s.enq_payload_i;
  end

  assign s.enq_rdy_o     = ~full;
  assign s.deq_vld_o     = grant_vld;
  assign s.deq_vc_o      = grant_vld ? grant : '0;
  assign s.deq_payload_o = grant_vld ? mem_q[grant][rd_ptr_q[grant]] : '0;

`ifdef STREAM_FIFO_VC_OCC_EN
  assign occ_o = cnt_q;
`endif

endmodule

// File: tb/tb_stream_fifo_vc.sv
// Directed bench for stream_fifo_vc: queue-based reference model checked every cycle.
module tb_stream_fifo_vc;
  localparam int NV = 4, DP = 4, WW = 64, CW = 3;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  stream_fifo_vc_if #(.NumVc(NV), .WordWidth(WW)) bus ();

`ifdef STREAM_FIFO_VC_OCC_EN
  logic [NV*CW-1:0] occ;
  stream_fifo_vc #(.NumVc(NV), .Depth(DP), .WordWidth(WW)) dut (
    .clk(clk), .rstn(rstn), .s(bus), .occ_o(occ));
`else
  stream_fifo_vc #(.NumVc(NV), .Depth(DP), .WordWidth(WW)) dut (
    .clk(clk), .rstn(rstn), .s(bus));
`endif

  int total = 0, bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [1:0] vc; logic [63:0] pl; } beat_t;

  // Reference model: one queue per VC, rr start, and the beat held while stalled.
  logic [WW-1:0] q [NV][$];
  int            rr = 0;
  bit            held = 0;
  int            held_vc = 0;
  beat_t         log_q [$];

  always @(negedge clk) begin : cmp
    logic [NV-1:0] e_rdy;
    bit            e_vld;
    int            e_vc;
    logic [WW-1:0] e_pl;
    if (!rstn) begin
      for (int v = 0; v < NV; v++) q[v].delete();
      rr = 0; held = 0;
      chk("rst_rdy", 64'(bus.enq_rdy_o), 64'hF);
      chk("rst_vld", 64'(bus.deq_vld_o), 64'h0);
      chk("rst_vc",  64'(bus.deq_vc_o), 64'h0);
      chk("rst_pl",  bus.deq_payload_o, 64'h0);
    end else begin
      for (int v = 0; v < NV; v++) e_rdy[v] = q[v].size() != DP;
      e_vld = 0; e_vc = 0;
      if (held) begin
        e_vld = 1; e_vc = held_vc;
      end else begin
        for (int i = 0; i < NV; i++) begin
          int idx;
          idx = (rr + i) % NV;
          if (!e_vld && q[idx].size() > 0) begin e_vld = 1; e_vc = idx; end
        end
      end
      e_pl = e_vld ? q[e_vc][0] : '0;
      chk("enq_rdy", 64'(bus.enq_rdy_o), 64'(e_rdy));
      chk("deq_vld", 64'(bus.deq_vld_o), 64'(e_vld));
      chk("deq_vc",  64'(bus.deq_vc_o), 64'(e_vc));
      chk("deq_pl",  bus.deq_payload_o, e_pl);
`ifdef STREAM_FIFO_VC_OCC_EN
      for (int v = 0; v < NV; v++) chk("occ", 64'(occ[v*CW +: CW]), 64'(q[v].size()));
`endif
      if (bus.deq_vld_o && bus.deq_rdy_i && !bus.flush_i)
        log_q.push_back('{vc: bus.deq_vc_o, pl: bus.deq_payload_o});
      if (bus.flush_i) begin
        for (int v = 0; v < NV; v++) q[v].delete();
        rr = 0; held = 0;
      end else begin
        if (e_vld && bus.deq_rdy_i) begin
          void'(q[e_vc].pop_front());
          rr = (e_vc + 1) % NV;
          held = 0;
        end else if (e_vld) begin
          held = 1; held_vc = e_vc;
        end
        if (bus.enq_vld_i && int'(bus.enq_vc_i) < NV && e_rdy[bus.enq_vc_i])
          q[bus.enq_vc_i].push_back(bus.enq_payload_i);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic enq(int vc, logic [63:0] pl);
    bus.enq_vld_i = 1'b1; bus.enq_vc_i = 2'(vc); bus.enq_payload_i = pl;
    step();
    bus.enq_vld_i = 1'b0;
  endtask

  initial begin
    bus.enq_vld_i = 0; bus.enq_vc_i = 0; bus.enq_payload_i = 0;
    bus.deq_rdy_i = 0; bus.flush_i = 0;
    step(2);
    rstn = 1'b1;
    step();

    // 1: async reset while an enqueue is being presented
    enq(0, 64'h10); enq(0, 64'h11);
    bus.enq_vld_i = 1; bus.enq_vc_i = 2'd1; bus.enq_payload_i = 64'h12;
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("t1_rdy", 64'(bus.enq_rdy_o), 64'hF);
    chk("t1_vld", 64'(bus.deq_vld_o), 64'h0);
`ifdef STREAM_FIFO_VC_OCC_EN
    chk("t1_occ", 64'(occ), 64'h0);
`endif
    step();
    bus.enq_vld_i = 0; rstn = 1'b1;
    step();

    // 2: fill VC2, fifth beat refused, drain in order
    log_q.delete();
    for (int i = 0; i < 4; i++) enq(2, 64'hA0 + 64'(i));
    chk("t2_rdy_full", 64'(bus.enq_rdy_o), 64'hB);
    bus.enq_vld_i = 1; bus.enq_vc_i = 2'd2; bus.enq_payload_i = 64'hA4;
    step();
    bus.enq_vld_i = 0;
    bus.deq_rdy_i = 1; step(4); bus.deq_rdy_i = 0;
    chk("t2_cnt", 64'(log_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("t2_vc", 64'(log_q[i].vc), 64'd2);
      chk("t2_pl", log_q[i].pl, 64'hA0 + 64'(i));
    end
    chk("t2_empty", 64'(bus.deq_vld_o), 64'h0);
    bus.flush_i = 1; step(); bus.flush_i = 0;

    // 3: round-robin order across all VCs, then VC0/VC3 refill
    log_q.delete();
    for (int v = 0; v < 4; v++) enq(v, 64'hB0 + 64'(v));
    bus.deq_rdy_i = 1; step(4); bus.deq_rdy_i = 0;
    chk("t3_cnt", 64'(log_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("t3_vc", 64'(log_q[i].vc), 64'(i));
      chk("t3_pl", log_q[i].pl, 64'hB0 + 64'(i));
    end
    log_q.delete();
    enq(0, 64'hC0); enq(3, 64'hC3);
    bus.deq_rdy_i = 1; step(2); bus.deq_rdy_i = 0;
    chk("t3b_cnt", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("t3b_vc0", 64'(log_q[0].vc), 64'd0);
      chk("t3b_vc1", 64'(log_q[1].vc), 64'd3);
    end

    // 4: lock holds VC3 even after higher-priority VC0 becomes non-empty
    log_q.delete();
    enq(3, 64'hD3); enq(0, 64'hD0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_vld", 64'(bus.deq_vld_o), 64'h1);
      chk("t4_vc", 64'(bus.deq_vc_o), 64'd3);
      chk("t4_pl", bus.deq_payload_o, 64'hD3);
      step();
    end
    bus.deq_rdy_i = 1; step(2); bus.deq_rdy_i = 0;
    chk("t4_cnt", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("t4_first", 64'(log_q[0]), 64'({2'd3, 64'hD3}));
      chk("t4_second", 64'(log_q[1]), 64'({2'd0, 64'hD0}));
    end

    // 5: simultaneous enq+deq on VC1 at count 2
    log_q.delete();
    enq(1, 64'hE0); enq(1, 64'hE1);
    bus.deq_rdy_i = 1;
    for (int i = 0; i < 10; i++) begin
      bus.enq_vld_i = 1; bus.enq_vc_i = 2'd1; bus.enq_payload_i = 64'hE2 + 64'(i);
      step();
`ifdef STREAM_FIFO_VC_OCC_EN
      chk("t5_occ", 64'(occ[CW +: CW]), 64'd2);
`endif
      chk("t5_rdy", 64'(bus.enq_rdy_o), 64'hF);
    end
    bus.enq_vld_i = 0;
    step(2); bus.deq_rdy_i = 0;
    chk("t5_cnt", 64'(log_q.size()), 64'd12);
    for (int i = 0; i < 12 && i < log_q.size(); i++) begin
      chk("t5_vc", 64'(log_q[i].vc), 64'd1);
      chk("t5_pl", log_q[i].pl, 64'hE0 + 64'(i));
    end

    // 6: flush while all VCs hold data and the arbiter is locked
    for (int v = 0; v < 4; v++) enq(v, 64'hF0 + 64'(v));
    chk("t6_pre_rdy", 64'(bus.enq_rdy_o), 64'hF);
    bus.flush_i = 1;
    bus.enq_vld_i = 1; bus.enq_vc_i = 2'd2; bus.enq_payload_i = 64'h77;
    chk("t6_vld_during", 64'(bus.deq_vld_o), 64'h1);
    step();
    bus.flush_i = 0; bus.enq_vld_i = 0;
    chk("t6_vld_after", 64'(bus.deq_vld_o), 64'h0);
    chk("t6_rdy_after", 64'(bus.enq_rdy_o), 64'hF);
    chk("t6_pl_after", bus.deq_payload_o, 64'h0);
    log_q.delete();
    bus.deq_rdy_i = 1;
    enq(2, 64'h55);
    step();
    bus.deq_rdy_i = 0;
    chk("t6_post_cnt", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) chk("t6_post", 64'(log_q[0]), 64'({2'd2, 64'h55}));

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
